pc_redirect_ctrl: RTL and testbench

Control-flow redirect controller in the MEM stage of the pipelined CPU. It turns resolved branch, JAL and JALR outcomes into the next-PC operation and operands that drive the next-PC selector. It flushes the wrong-path instructions in the younger stages. If the hazard unit blocks the PC write when a redirect arrives, it buffers the redirect and replays it.

---
 rtl/pc_redirect_ctrl.sv | 148 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// MEM-stage control-flow redirect: turns resolved branch/JAL/JALR into
// next-PC selector controls, flushes wrong-path stages, replays stalled redirects.
module pc_redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_br,
    input  logic             mem_br_taken,
    input  logic             mem_jal,
    input  logic             mem_jalr,
    input  logic [31:0]      mem_pc,
    input  logic [31:0]      mem_imm,
    input  logic [31:0]      mem_alu,
    input  logic             pc_stall,
    output logic [2:0]       npc_op,
    output logic [31:0]      npc_pc,
    output logic [31:0]      npc_imm,
    output logic [31:0]      npc_base,
    output logic             j_fetch,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             pending,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JALR   = 3'b100;

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] base;
    } redir_t;

    state_t            state;
    redir_t            rbuf;
    logic              req;
    logic [2:0]        req_op;
    logic              apply;
    logic              capture;
    logic              flush;
    logic [CNT_W-1:0]  cnt_q;

    assign req = mem_valid & (mem_jalr | mem_jal | (mem_br & mem_br_taken));

    // Illegal multi-hot type bits still resolve deterministically
    always_comb begin
        req_op = OP_BRANCH;
        priority case (1'b1)
            mem_jalr: req_op = OP_JALR;
            mem_jal:  req_op = OP_JUMP;
            default:  req_op = OP_BRANCH;
        endcase
    end

    always_comb begin
        npc_op   = OP_PLUS4;
        npc_pc   = mem_pc;
        npc_imm  = mem_imm;
        npc_base = mem_alu;
        j_fetch  = pc_stall;
        flush    = 1'b0;
        apply    = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    flush = 1'b1;
                    if (pc_stall) begin
                        j_fetch = 1'b1;
                        capture = 1'b1;
                    end else begin
                        npc_op  = req_op;
                        j_fetch = 1'b0;
                        apply   = 1'b1;
                    end
                end
            end
            PENDING: begin
                // MEM contents are wrong-path here; only the buffer matters
                flush    = 1'b1;
                npc_pc   = rbuf.pc;
                npc_imm  = rbuf.imm;
                npc_base = rbuf.base;
                if (pc_stall) begin
                    j_fetch = 1'b1;
                end else begin
                    npc_op  = rbuf.op;
                    j_fetch = 1'b0;
                    apply   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign flush_ex_mem = flush;
    assign redirect_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rbuf    <= '0;
            cnt_q   <= '0;
            pending <= 1'b0;
        end else begin
            if (apply && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        rbuf.op   <= req_op;
                        rbuf.pc   <= mem_pc;
                        rbuf.imm  <= mem_imm;
                        rbuf.base <= mem_alu;
                        state     <= PENDING;
                        pending   <= 1'b1;
                    end
                end
                PENDING: begin
                    if (apply) begin
                        state   <= IDLE;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares.
module tb_pc_redirect_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, mem_br, mem_br_taken, mem_jal, mem_jalr;
    logic [31:0]   mem_pc, mem_imm, mem_alu;
    logic          pc_stall;
    logic [2:0]    npc_op;
    logic [31:0]   npc_pc, npc_imm, npc_base;
    logic          j_fetch, flush_if_id, flush_id_ex, flush_ex_mem, pending;
    logic [CW-1:0] redirect_cnt;

    typedef struct {
        string         name;
        logic [2:0]    op;
        logic [31:0]   pc;
        logic [31:0]   imm;
        logic [31:0]   base;
        logic          jf;
        logic [2:0]    fl;
        logic          pend;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    pc_redirect_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_br(mem_br), .mem_br_taken(mem_br_taken),
        .mem_jal(mem_jal), .mem_jalr(mem_jalr),
        .mem_pc(mem_pc), .mem_imm(mem_imm), .mem_alu(mem_alu),
        .pc_stall(pc_stall),
        .npc_op(npc_op), .npc_pc(npc_pc), .npc_imm(npc_imm), .npc_base(npc_base),
        .j_fetch(j_fetch),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .pending(pending), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
    endfunction

    // Monitor: outputs are presented every cycle, so one expectation per cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "npc_op",   {29'd0, npc_op}, {29'd0, e.op});
            chk(e.name, "npc_pc",   npc_pc, e.pc);
            chk(e.name, "npc_imm",  npc_imm, e.imm);
            chk(e.name, "npc_base", npc_base, e.base);
            chk(e.name, "j_fetch",  {31'd0, j_fetch}, {31'd0, e.jf});
            chk(e.name, "flush",    {29'd0, flush_if_id, flush_id_ex, flush_ex_mem},
                {29'd0, e.fl});
            chk(e.name, "pending",  {31'd0, pending}, {31'd0, e.pend});
            chk(e.name, "cnt",      {{(32-CW){1'b0}}, redirect_cnt},
                {{(32-CW){1'b0}}, e.cnt});
        end
    end

    task automatic drive(input logic r, input logic v, input logic br, input logic tk,
                         input logic jal, input logic jalr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] alu, input logic st);
        @(posedge clk);
        #1;
        rst = r; mem_valid = v; mem_br = br; mem_br_taken = tk;
        mem_jal = jal; mem_jalr = jalr;
        mem_pc = pc; mem_imm = imm; mem_alu = alu; pc_stall = st;
    endtask

    task automatic expect_(input string nm, input logic [2:0] op, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [31:0] base, input logic jf,
                           input logic [2:0] fl, input logic pend, input logic [CW-1:0] cnt);
        exp_t e;
        e.name = nm; e.op = op; e.pc = pc; e.imm = imm; e.base = base;
        e.jf = jf; e.fl = fl; e.pend = pend; e.cnt = cnt;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; mem_valid = 0; mem_br = 0; mem_br_taken = 0; mem_jal = 0;
        mem_jalr = 0; mem_pc = 0; mem_imm = 0; mem_alu = 0; pc_stall = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("reset", 3'b000, 0, 0, 0, 0, 3'b000, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("idle0", 3'b000, 0, 0, 0, 0, 3'b000, 0, 0);

        drive(0, 1, 1, 1, 0, 0, 32'h100, 32'h20, 0, 0);
        expect_("br_taken", 3'b001, 32'h100, 32'h20, 0, 0, 3'b111, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("after_br", 3'b000, 0, 0, 0, 0, 3'b000, 0, 1);
        drive(0, 1, 1, 0, 0, 0, 32'h100, 32'h20, 0, 0);
        expect_("br_not_taken", 3'b000, 32'h100, 32'h20, 0, 0, 3'b000, 0, 1);

        drive(0, 1, 0, 0, 0, 1, 32'h200, 32'h8, 32'h400, 1);
        expect_("jalr_stall1", 3'b000, 32'h200, 32'h8, 32'h400, 1, 3'b111, 0, 1);
        drive(0, 1, 0, 0, 1, 0, 32'h300, 32'h44, 32'h55, 1);
        expect_("jalr_stall2", 3'b000, 32'h200, 32'h8, 32'h400, 1, 3'b111, 1, 1);
        drive(0, 1, 0, 0, 1, 0, 32'h300, 32'h44, 32'h55, 0);
        expect_("jalr_drain", 3'b100, 32'h200, 32'h8, 32'h400, 0, 3'b111, 1, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("after_drain", 3'b000, 0, 0, 0, 0, 3'b000, 0, 2);

        drive(0, 1, 0, 0, 1, 1, 32'h10, 32'h4, 32'h80, 0);
        expect_("prio_jalr", 3'b100, 32'h10, 32'h4, 32'h80, 0, 3'b111, 0, 2);
        drive(0, 1, 0, 0, 1, 0, 32'h14, 32'hc, 32'h0, 0);
        expect_("jal", 3'b010, 32'h14, 32'hc, 0, 0, 3'b111, 0, 3);
        drive(0, 0, 1, 1, 1, 1, 32'h18, 32'h4, 32'h9, 1);
        expect_("invalid_req", 3'b000, 32'h18, 32'h4, 32'h9, 1, 3'b000, 0, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("no_capture", 3'b000, 0, 0, 0, 0, 3'b000, 0, 4);

        drive(0, 1, 1, 1, 0, 0, 32'h500, 32'h10, 0, 1);
        expect_("br_stall", 3'b000, 32'h500, 32'h10, 0, 1, 3'b111, 0, 4);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        expect_("rst_in_pend", 3'b000, 32'h500, 32'h10, 0, 1, 3'b111, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("after_rst", 3'b000, 0, 0, 0, 0, 3'b000, 0, 0);

        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 1, 0, 0, 32'h1000 + 32'(i), 32'h4, 0, 0);
            expect_("sat", 3'b001, 32'h1000 + 32'(i), 32'h4, 0, 0, 3'b111, 0,
                    (i > 15) ? 4'hF : 4'(i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_("sat_final", 3'b000, 0, 0, 0, 0, 3'b000, 0, 4'hF);

        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (q.size() > 0) begin
                total++;
                $display("FAIL drain_timeout actual=%0d expected=0", q.size());
            end
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
